// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) round-robin arbiter in front of a single-port RAM.
// Each access takes IDLE->BUSY->RESP, so the ack comes two cycles after the
// request is sampled and the arbiter completes one access every three cycles.
//
// Ports:
//   CLK, reset             clock and asynchronous active-high reset
//   if_req/if_addr         fetch read request; if_ack/if_rdata reply
//   d_req/d_we/d_addr/
//   d_wdata                data load/store request; d_ack/d_rdata reply
//   err                    high with the ack of a rejected access
//   mem_addr/mem_wdata/
//   mem_read/mem_write     RAM command, driven only in BUSY
//   mem_rdata              big-endian RAM word, combinational from mem_addr
module mem_arbiter #(
    parameter int RAM_BYTES = 1024
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] MAX_ADDR = 32'(RAM_BYTES - 4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Latched request: port 1 = data, 0 = fetch.
    logic        lat_port;
    logic [31:0] lat_addr;
    logic        lat_we;
    logic [31:0] lat_wdata;
    logic        lat_bad;

    // 1 when the most recent grant went to the data port.
    logic        last_d;

    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;

    logic [15:0] fetch_cnt;
    logic [15:0] data_cnt;

    logic        gnt_d;
    logic        gnt_if;
    logic [31:0] sel_addr;
    logic        sel_we;
    logic        sel_bad;
    logic        grant;

    // Data wins if alone, or on a tie when fetch had the last grant.
    always_comb begin
        gnt_d    = d_req & (~if_req | ~last_d);
        gnt_if   = if_req & ~gnt_d;
        grant    = (state == IDLE) & (gnt_d | gnt_if);
        sel_addr = gnt_d ? d_addr : if_addr;
        sel_we   = gnt_d & d_we;
        sel_bad  = (sel_addr > MAX_ADDR) | (sel_addr[1:0] != 2'b00);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if_ack    = 1'b0;
        d_ack     = 1'b0;
        err       = 1'b0;
        unique case (state)
            IDLE: begin
                if (if_req | d_req) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                state_nxt = RESP;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
                mem_read  = ~lat_we & ~lat_bad;
                mem_write = lat_we & ~lat_bad;
            end
            RESP: begin
                state_nxt = IDLE;
                if_ack    = ~lat_port;
                d_ack     = lat_port;
                err       = lat_bad;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            lat_port  <= 1'b0;
            lat_addr  <= 32'd0;
            lat_we    <= 1'b0;
            lat_wdata <= 32'd0;
            lat_bad   <= 1'b0;
            last_d    <= 1'b1;
        end else if (grant) begin
            lat_port  <= gnt_d;
            lat_addr  <= sel_addr;
            lat_we    <= sel_we;
            lat_wdata <= gnt_d ? d_wdata : 32'd0;
            lat_bad   <= sel_bad;
            last_d    <= gnt_d;
        end
    end

    // Rejected accesses return zero; good stores keep the old value.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else if (state == BUSY) begin
            if (lat_port) begin
                if (lat_bad) begin
                    d_rdata_q <= 32'd0;
                end else if (!lat_we) begin
                    d_rdata_q <= mem_rdata;
                end
            end else begin
                if (lat_bad) begin
                    if_rdata_q <= 32'd0;
                end else begin
                    if_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            fetch_cnt <= 16'd0;
            data_cnt  <= 16'd0;
        end else if (grant) begin
            if (gnt_if && fetch_cnt != 16'hFFFF) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
            if (gnt_d && data_cnt != 16'hFFFF) begin
                data_cnt <= data_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte RAM model and an ack scoreboard.
// Ports: none (top-level bench).
module tb_mem_arbiter;

    localparam int RAM_BYTES = 1024;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    mem_arbiter #(.RAM_BYTES(RAM_BYTES)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .err      (err),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          mem_act = 0;
    logic [31:0] m_if = 32'd0;
    logic [31:0] m_d = 32'd0;
    logic [7:0]  ram [RAM_BYTES];

    always @(posedge CLK) cyc <= cyc + 1;

    // Big-endian byte RAM; preloaded on the first edge while reset is held.
    always_comb begin
        mem_rdata = 32'd0;
        if (mem_addr <= 32'(RAM_BYTES - 4))
            mem_rdata = {ram[mem_addr], ram[mem_addr + 1],
                         ram[mem_addr + 2], ram[mem_addr + 3]};
    end

    always @(posedge CLK) begin
        if (cyc == 0) begin
            for (int i = 0; i < RAM_BYTES; i++) ram[i] <= 8'h00;
            ram[32'h100] <= 8'h11; ram[32'h101] <= 8'h22;
            ram[32'h102] <= 8'h33; ram[32'h103] <= 8'h44;
            ram[32'h20]  <= 8'hA0; ram[32'h21]  <= 8'hA1;
            ram[32'h22]  <= 8'hA2; ram[32'h23]  <= 8'hA3;
            ram[RAM_BYTES - 4] <= 8'h5A; ram[RAM_BYTES - 3] <= 8'hA5;
            ram[RAM_BYTES - 2] <= 8'hC3; ram[RAM_BYTES - 1] <= 8'h3C;
        end else if (mem_write && mem_addr <= 32'(RAM_BYTES - 4)) begin
            ram[mem_addr]     <= mem_wdata[31:24];
            ram[mem_addr + 1] <= mem_wdata[23:16];
            ram[mem_addr + 2] <= mem_wdata[15:8];
            ram[mem_addr + 3] <= mem_wdata[7:0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each ack pops the oldest expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (mem_read | mem_write) mem_act++;
        if (if_ack | d_ack) begin
            chk("one_ack", {31'd0, if_ack & d_ack}, 32'd0);
            chk("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("ack_port", {31'd0, d_ack}, {31'd0, e.port});
                chk("ack_rdata", d_ack ? d_rdata : if_rdata, e.rdata);
                chk("ack_err", {31'd0, err}, {31'd0, e.err});
                chk("ack_cycle", cyc, e.cyc);
            end
        end else begin
            chk("err_idle", {31'd0, err}, 32'd0);
        end
    end

    task automatic push_exp(input logic dp, input logic we,
                            input logic [31:0] rd, input logic er,
                            input int at);
        exp_t e;
        if (er) begin
            if (dp) m_d = 32'd0; else m_if = 32'd0;
        end else if (!we) begin
            if (dp) m_d = rd; else m_if = rd;
        end
        e.port  = dp;
        e.rdata = dp ? m_d : m_if;
        e.err   = er;
        e.cyc   = at;
        sb.push_back(e);
    endtask

    task automatic access(input logic dp, input logic we,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input logic er);
        logic got;
        @(negedge CLK);
        if (dp) begin
            d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        push_exp(dp, dp & we, rd, er, cyc + 2);
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (dp ? d_ack : if_ack) begin
                got = 1'b1;
                break;
            end
        end
        chk("ack_timeout", {31'd0, got}, 32'd1);
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int act0;
        repeat (2) @(negedge CLK);
        chk("rst_acks", {29'd0, if_ack, d_ack, err}, 32'd0);
        chk("rst_mem_ctl", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", if_rdata | d_rdata, 32'd0);
        chk("rst_cnt", {dut.fetch_cnt, dut.data_cnt}, 32'd0);
        reset = 1'b0;

        access(1'b0, 1'b0, 32'h100, 32'd0, 32'h11223344, 1'b0);
        access(1'b1, 1'b1, 32'h8, 32'hDEADBEEF, 32'd0, 1'b0);
        access(1'b1, 1'b0, 32'h8, 32'd0, 32'hDEADBEEF, 1'b0);
        chk("ram_8_11", {ram[8], ram[9], ram[10], ram[11]}, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'(RAM_BYTES - 4), 32'd0, 32'h5AA5C33C, 1'b0);

        act0 = mem_act;
        access(1'b1, 1'b0, 32'(RAM_BYTES - 3), 32'd0, 32'd0, 1'b1);
        access(1'b1, 1'b0, 32'h6, 32'd0, 32'd0, 1'b1);
        chk("reject_no_mem", mem_act, act0);

        // Both ports held high across reset: fetch, data, fetch, data.
        @(negedge CLK);
        reset = 1'b1;
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
        m_if = 32'd0; m_d = 32'd0;
        @(negedge CLK);
        reset = 1'b0;
        push_exp(1'b0, 1'b0, 32'h11223344, 1'b0, cyc + 2);
        push_exp(1'b1, 1'b0, 32'hDEADBEEF, 1'b0, cyc + 5);
        push_exp(1'b0, 1'b0, 32'h11223344, 1'b0, cyc + 8);
        push_exp(1'b1, 1'b0, 32'hDEADBEEF, 1'b0, cyc + 11);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (if_ack | d_ack) n++;
            if (n == 4) break;
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("alt_acks", n, 4);
        chk("fetch_cnt", {16'd0, dut.fetch_cnt}, 32'd2);
        chk("data_cnt", {16'd0, dut.data_cnt}, 32'd2);
        chk("cnt_equal", {16'd0, dut.fetch_cnt}, {16'd0, dut.data_cnt});

        // Reset lands in BUSY of a store: the write must never happen.
        @(negedge CLK);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
        @(posedge CLK);
        #1;
        chk("st_busy_wr", {31'd0, mem_write}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_busy_wr", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_busy_addr", mem_addr | mem_wdata, 32'd0);
        chk("rst_busy_acks", {29'd0, if_ack, d_ack, err}, 32'd0);
        chk("rst_busy_rdata", if_rdata | d_rdata, 32'd0);
        repeat (3) @(negedge CLK);
        d_req = 1'b0; d_we = 1'b0;
        reset = 1'b0;
        repeat (4) @(negedge CLK);
        chk("ram_20_23", {ram[32'h20], ram[32'h21], ram[32'h22], ram[32'h23]},
            32'hA0A1A2A3);
        chk("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RAM_BYTES, default 1024, meaning the byte size of the shared RAM; legal addresses are 0..RAM_BYTES-4.
REQ-002 SHALL have port CLK, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port if_req, input, 1, instruction-fetch read request, held until if_ack.
REQ-005 SHALL have port if_addr, input, 32, fetch byte address.
REQ-006 SHALL have port if_ack, output, 1, one-cycle completion pulse for fetch.
REQ-007 SHALL have port if_rdata, output, 32, fetch read data, valid while if_ack=1.
REQ-008 SHALL have port d_req, input, 1, data request, held until d_ack.
REQ-009 SHALL have port d_we, input, 1, 1=store word, 0=load word.
REQ-010 SHALL have port d_addr, input, 32, data byte address.
REQ-011 SHALL have port d_wdata, input, 32, store data.
REQ-012 SHALL have port d_ack, output, 1, one-cycle completion pulse for data.
REQ-013 SHALL have port d_rdata, output, 32, load data, valid while d_ack=1 and d_we was 0.
REQ-014 SHALL have port err, output, 1, asserted with the ack of a rejected access.
REQ-015 SHALL have ports mem_addr (output, 32), mem_wdata (output, 32), mem_read (output, 1), mem_write (output, 1), driving the RAM.
REQ-016 SHALL have port mem_rdata, input, 32, big-endian word returned by the RAM combinationally from mem_addr.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, RESP; IDLE->BUSY on edge with any req; BUSY->RESP always; RESP->IDLE always.
REQ-018 SHALL, on the IDLE->BUSY edge, latch the winning port id, addr, we and wdata into internal registers; inputs are ignored afterwards until IDLE.
REQ-019 SHALL arbitrate round-robin: single requester wins; with both requesting, the port not granted last wins; last-grant pointer updates on every grant.
REQ-020 SHALL drive mem_addr/mem_wdata from latched registers during BUSY, mem_read=~we, mem_write=we, both 0 in IDLE and RESP.
REQ-021 SHALL treat fetch port as read-only (we forced 0).
REQ-022 SHALL capture mem_rdata into the winning port's rdata register on the BUSY->RESP edge for loads/fetches; stores leave rdata unchanged.
REQ-023 SHALL assert exactly one of if_ack/d_ack for exactly the RESP cycle; latency req-sampled edge to ack = 2 cycles; throughput one access per 3 cycles.
REQ-024 SHALL reject accesses with addr > RAM_BYTES-4 or addr[1:0]!=0: no mem_read/mem_write in BUSY, rdata=0, err=1 in RESP.
REQ-025 SHALL keep err=0 in all cycles except RESP of a rejected access.
REQ-026 SHALL accept a req still high during RESP as a new request only after returning to IDLE (requesters drop req on ack).
REQ-027 SHALL maintain 16-bit saturating counters of fetch and data grants, readable by hierarchy for debug; saturate at 65535, no wrap.

Reset
REQ-028 SHALL, on reset assertion, immediately (asynchronously) force state=IDLE, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, if_ack=0, d_ack=0, err=0, if_rdata=0, d_rdata=0, counters=0, last-grant=data (so fetch wins first tie).
REQ-029 SHALL, if reset asserts during BUSY of a store, drop mem_write before the next edge so no RAM write occurs, and issue no ack.

Verification
REQ-030 SHALL pass: RAM preloaded 0x100..0x103 = 11 22 33 44, if_req addr 0x100 -> if_ack 2 cycles later, if_rdata=0x11223344, err=0.
REQ-031 SHALL pass: d_req we=1 addr 0x8 wdata 0xDEADBEEF, then load 0x8 -> d_rdata=0xDEADBEEF; RAM bytes 8..11 = DE AD BE EF.
REQ-032 SHALL pass: if_req and d_req held continuously from reset -> grants alternate fetch, data, fetch, data; grant counters equal after 4 accesses.
REQ-033 SHALL pass: d_req load addr RAM_BYTES-3 and addr 0x6 -> d_ack with err=1, d_rdata=0, mem_read never asserted.
REQ-034 SHALL pass: reset asserted mid-BUSY of store 0x12345678 to 0x20 -> RAM 0x20..0x23 unchanged, no ack, outputs zero.
